// File: rtl/audio_pkg.sv
// Shared types and constants for the audio ROM streaming path.
package audio_pkg;

    localparam int FIFO_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } stream_state_t;

    // Sequential ROM walk with wrap at the last valid word.
    function automatic logic [31:0] wrap_incr(input logic [31:0] addr, input logic [31:0] last);
        return (addr == last) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/audio_rom_streamer_if.sv
// Streamer-side bus: stream enable, ROM fetch port and the sound-core pop port.
interface audio_rom_streamer_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int FIFO_DATA_WIDTH = audio_pkg::FIFO_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 16
) ();
    logic                            aud_en;
    logic [ADDR_WIDTH-1:0]           rom_addr;
    logic [FIFO_DATA_WIDTH-1:0]      rom_rd_data;
    logic                            fifo_rd_en;
    logic [FIFO_DATA_WIDTH-1:0]      fifo_rd_data;
    logic                            fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]     fifo_level;
    logic                            underflow;

    modport master (
        input  aud_en, rom_rd_data, fifo_rd_en,
        output rom_addr, fifo_rd_data, fifo_empty, fifo_level, underflow
    );

    modport slave (
        output aud_en, rom_rd_data, fifo_rd_en,
        input  rom_addr, fifo_rd_data, fifo_empty, fifo_level, underflow
    );
endinterface

// File: rtl/audio_rom_streamer_sync_fifo.sv
// Single-clock circular buffer with registered read, registered level/empty and a flush.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             push_ok, pop_ok;

    // Flush wins over both ports; pops on an empty buffer are ignored here.
    assign push_ok = push && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign full    = (level == LW'(DEPTH));

    always_comb begin
        level_nxt = level + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + PW'(1);
                rd_data <= mem[rd_ptr];
            end
            level <= level_nxt;
            empty <= (level_nxt == '0);
        end
    end

    // The in-flight word is reserved at fetch time, so a full buffer never sees a push.
    assert property (@(posedge clk) disable iff (!rstn) !(push_ok && full));

endmodule

// File: rtl/audio_rom_streamer.sv
// Flow-controlled ROM walker feeding the PWM audio core through a local FIFO.
module audio_rom_streamer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int ROM_DEPTH       = 1024,
    parameter int FIFO_DATA_WIDTH = audio_pkg::FIFO_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic               clk,
    input  logic               rstn,
    audio_rom_streamer_if.master bus
);
    import audio_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] LAST_ADDR = 32'(ROM_DEPTH - 1);

    stream_state_t              state;
    logic                       inflight;
    logic                       underflow_q;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [FIFO_DATA_WIDTH-1:0] rd_data;
    logic [LW-1:0]              level;
    logic                       empty, full;
    logic                       flush, pop_ok, fetch, push;

    // Dropping aud_en clears the path on the same edge; FLUSH just settles back to IDLE.
    assign flush  = (state == FLUSH) || (state == RUN && !bus.aud_en);
    assign pop_ok = bus.fifo_rd_en && !empty && !flush;
    assign push   = inflight && !flush;
    assign fetch  = (state == RUN) && bus.aud_en && !inflight && (!full || pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            inflight <= 1'b0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inflight <= 1'b0;
                    addr     <= '0;
                    if (bus.aud_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.aud_en) begin
                        state    <= FLUSH;
                        inflight <= 1'b0;
                        addr     <= '0;
                    end else if (inflight) begin
                        // ROM word for addr lands this cycle; step to the next one.
                        inflight <= 1'b0;
                        addr     <= ADDR_WIDTH'(wrap_incr(32'(addr), LAST_ADDR));
                    end else if (fetch) begin
                        inflight <= 1'b1;
                    end
                end
                FLUSH: begin
                    inflight <= 1'b0;
                    addr     <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    inflight <= 1'b0;
                    addr     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underflow_q <= 1'b0;
        end else if (bus.fifo_rd_en && empty) begin
            underflow_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .pop     (bus.fifo_rd_en),
        .flush   (flush),
        .wr_data (bus.rom_rd_data),
        .rd_data (rd_data),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    assign bus.rom_addr     = addr;
    assign bus.fifo_rd_data = rd_data;
    assign bus.fifo_empty   = empty;
    assign bus.fifo_level   = level;
    assign bus.underflow    = underflow_q;

endmodule
